// File: rtl/vx_batch_stream_arb_if.sv
// Bundle of the N-input / 1-output stream channel used by the batch arbiter.
// Handshake: a beat moves when valid and ready are both 1 at a rising clk edge.
// A source holds valid and payload until that happens; ready may depend on valid.
interface vx_batch_stream_arb_if #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
  logic [NUM_REQS-1:0]            valid_in;
  logic [NUM_REQS*DATA_WIDTH-1:0] data_in;
  logic [NUM_REQS-1:0]            ready_in;
  logic                           valid_out;
  logic [DATA_WIDTH-1:0]          data_out;
  logic [LOG_NUM_REQS-1:0]        sel_out;
  logic                           ready_out;

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, sel_out
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, sel_out
  );
endinterface

// File: rtl/vx_batch_stream_arb.sv
// Batch-fair arbiter merging NUM_REQS streams into one registered output stage.
// A batch is the set of requesters valid when it forms; each is served once, lowest index first.
module vx_batch_stream_arb #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input logic                  clk,
  input logic                  reset,
  vx_batch_stream_arb_if.slave io_bus
);

  logic                    w_space;
  logic                    w_xfer;
  logic [NUM_REQS-1:0]     w_grant_oh;
  logic [LOG_NUM_REQS-1:0] w_grant_idx;
  logic [DATA_WIDTH-1:0]   w_data_sel;

  logic                    r_valid_out;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic [LOG_NUM_REQS-1:0] r_sel_out;

  // Single-entry output register: it can take a new beat when empty or draining.
  assign w_space = !r_valid_out || io_bus.ready_out;

  generate
    if (NUM_REQS == 1) begin : g_pipe
      assign w_grant_oh      = 1'b1;
      assign w_grant_idx     = '0;
      assign w_xfer          = io_bus.valid_in[0] && w_space && !reset;
      assign io_bus.ready_in = w_space && !reset;
    end else begin : g_arb
      logic [NUM_REQS-1:0] r_batch;
      logic                r_use_batch;
      logic [NUM_REQS-1:0] w_masked;
      logic [NUM_REQS-1:0] w_pending;
      logic [NUM_REQS-1:0] w_remain;
      logic                w_any;

      // Fall back to the raw request vector as soon as no batch member is still valid,
      // so a new batch forms without an idle cycle.
      assign w_masked  = r_batch & io_bus.valid_in;
      assign w_pending = (r_use_batch && (|w_masked)) ? w_masked : io_bus.valid_in;

      always_comb begin
        w_grant_oh  = '0;
        w_grant_idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
          if (w_pending[i]) begin
            w_grant_oh  = NUM_REQS'(1) << i;
            w_grant_idx = LOG_NUM_REQS'(i);
          end
        end
      end

      assign w_any           = |w_pending;
      assign w_xfer          = w_any && w_space && !reset;
      assign w_remain        = w_pending & ~w_grant_oh;
      assign io_bus.ready_in = w_xfer ? w_grant_oh : '0;

      // Batch state only moves on an accepted beat, so a stalled output locks the grant.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_batch     <= '0;
          r_use_batch <= 1'b0;
        end else if (w_xfer) begin
          r_batch     <= w_remain;
          r_use_batch <= |w_remain;
        end
      end
    end
  endgenerate

  // AND-OR select: payload of streams without the grant can never leak through.
  always_comb begin
    w_data_sel = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_data_sel = w_data_sel |
                   (io_bus.data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant_oh[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_sel_out   <= '0;
    end else if (w_xfer) begin
      r_valid_out <= 1'b1;
      r_data_out  <= w_data_sel;
      r_sel_out   <= w_grant_idx;
    end else if (io_bus.ready_out) begin
      r_valid_out <= 1'b0;
    end
  end

  assign io_bus.valid_out = r_valid_out;
  assign io_bus.data_out  = r_data_out;
  assign io_bus.sel_out   = r_sel_out;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(io_bus.ready_in));

  a_ready_needs_valid: assert property (@(posedge clk)
    (io_bus.ready_in & ~io_bus.valid_in) == '0);

  a_reset_no_ready: assert property (@(posedge clk) reset |-> (io_bus.ready_in == '0));

  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (r_valid_out && !io_bus.ready_out) |=>
      (r_valid_out && $stable(r_data_out) && $stable(r_sel_out)));

endmodule

// File: tb/tb_vx_batch_stream_arb.sv
// Directed checks of batch ordering, stall and reset on a 4-input arbiter,
// plus a scoreboarded random-handshake run on a 5-input arbiter.
module tb_vx_batch_stream_arb;
  localparam int NA  = 4;
  localparam int DWA = 32;
  localparam int NB  = 5;
  localparam int DWB = 16;
  localparam int LB  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  vx_batch_stream_arb_if #(.NUM_REQS(NA), .DATA_WIDTH(DWA)) a_if ();
  vx_batch_stream_arb_if #(.NUM_REQS(NB), .DATA_WIDTH(DWB)) b_if ();

  vx_batch_stream_arb #(.NUM_REQS(NA), .DATA_WIDTH(DWA)) u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .io_bus (a_if)
  );

  vx_batch_stream_arb #(.NUM_REQS(NB), .DATA_WIDTH(DWB)) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .io_bus (b_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [LB+DWB-1:0] exp_q[$];
  int                wait_cnt[NB];
  int                n_in  = 0;
  int                n_out = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dat_a(input int i);
    return 32'(32'h1111_1111 * (i + 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    a_if.valid_in   = '0;
    a_if.ready_out  = 1'b1;
    b_if.valid_in   = '0;
    b_if.ready_out  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Check ready_in for the inputs already driven, clock once, then check the output register.
  task automatic cyc(input string tag, input logic [NA-1:0] e_rdy, input logic e_v,
                     input logic [31:0] e_sel, input logic [31:0] e_dat);
    #1;
    check({tag, "_rdy"}, 32'(a_if.ready_in), 32'(e_rdy));
    tick();
    check({tag, "_vout"}, 32'(a_if.valid_out), 32'(e_v));
    check({tag, "_sel"},  32'(a_if.sel_out), e_sel);
    check({tag, "_data"}, a_if.data_out, e_dat);
  endtask

  task automatic stress_cycle(input bit drain);
    logic [NB-1:0]     acc;
    logic [LB+DWB-1:0] e;
    for (int i = 0; i < NB; i++) begin
      if (!drain && !b_if.valid_in[i] && ($urandom_range(0, 2) != 0)) begin
        b_if.valid_in[i]             = 1'b1;
        b_if.data_in[i*DWB +: DWB] = DWB'($urandom_range(0, 65535));
      end
    end
    b_if.ready_out = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    check("b_onehot", 32'($onehot0(b_if.ready_in)), 32'd1);
    check("b_rdy_valid", 32'(b_if.ready_in & ~b_if.valid_in), 32'd0);
    if (b_if.valid_out && b_if.ready_out) begin
      if (exp_q.size() == 0) begin
        check("b_sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("b_sel",  32'(b_if.sel_out), 32'(e[DWB +: LB]));
        check("b_data", 32'(b_if.data_out), 32'(e[DWB-1:0]));
        n_out++;
      end
    end
    acc = b_if.valid_in & b_if.ready_in;
    for (int i = 0; i < NB; i++) begin
      if (acc[i]) begin
        exp_q.push_back({LB'(i), b_if.data_in[i*DWB +: DWB]});
        n_in++;
        wait_cnt[i] = 0;
      end else if (b_if.valid_in[i] && (acc != '0)) begin
        // A late arrival may sit out the rest of one batch plus the lower-index part of the next.
        wait_cnt[i]++;
        check("b_starve", 32'(wait_cnt[i] <= 2 * NB - 3), 32'd1);
      end
    end
    tick();
    b_if.valid_in = b_if.valid_in & ~acc;
  endtask

  initial begin
    a_if.valid_in  = '0;
    a_if.ready_out = 1'b1;
    for (int i = 0; i < NA; i++) a_if.data_in[i*DWA +: DWA] = dat_a(i);
    b_if.valid_in  = '0;
    b_if.data_in   = '0;
    b_if.ready_out = 1'b1;
    for (int i = 0; i < NB; i++) wait_cnt[i] = 0;

    // Reset with every stream requesting: nothing may be accepted.
    reset         = 1'b1;
    a_if.valid_in = 4'b1111;
    tick();
    tick();
    check("rst_rdy",  32'(a_if.ready_in), 32'd0);
    check("rst_vout", 32'(a_if.valid_out), 32'd0);
    check("rst_sel",  32'(a_if.sel_out), 32'd0);
    check("rst_data", a_if.data_out, 32'd0);

    // All four held valid: round-robin-like 0,1,2,3,0,... with back-to-back output.
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc("t_full", 4'(1 << (k % 4)), 1'b1, 32'(k % 4), dat_a(k % 4));
    end

    // Stream 1 arriving after batch {0,2} forms waits for stream 2.
    do_reset();
    a_if.valid_in = 4'b0101;
    cyc("t_late_a", 4'b0001, 1'b1, 32'd0, dat_a(0));
    a_if.valid_in = 4'b0110;
    cyc("t_late_b", 4'b0100, 1'b1, 32'd2, dat_a(2));
    a_if.valid_in = 4'b0010;
    cyc("t_late_c", 4'b0010, 1'b1, 32'd1, dat_a(1));

    // Output stall for three cycles holds the register and freezes the grant.
    do_reset();
    a_if.valid_in = 4'b0011;
    cyc("t_stall_a", 4'b0001, 1'b1, 32'd0, dat_a(0));
    a_if.ready_out = 1'b0;
    for (int k = 0; k < 3; k++) cyc("t_stall_s", 4'b0000, 1'b1, 32'd0, dat_a(0));
    a_if.ready_out = 1'b1;
    cyc("t_stall_b", 4'b0010, 1'b1, 32'd1, dat_a(1));
    cyc("t_stall_c", 4'b0001, 1'b1, 32'd0, dat_a(0));

    // Batch {1,3}: stream 3 drops, stream 0 served at once from a new batch.
    do_reset();
    a_if.valid_in = 4'b1010;
    cyc("t_drop_a", 4'b0010, 1'b1, 32'd1, dat_a(1));
    a_if.valid_in = 4'b0001;
    cyc("t_drop_b", 4'b0001, 1'b1, 32'd0, dat_a(0));

    // Reset while the output is stalled discards the held beat.
    do_reset();
    a_if.valid_in  = 4'b0001;
    a_if.ready_out = 1'b0;
    cyc("t_mrst_a", 4'b0001, 1'b1, 32'd0, dat_a(0));
    reset         = 1'b1;
    a_if.valid_in = 4'b0110;
    cyc("t_mrst_r", 4'b0000, 1'b0, 32'd0, 32'd0);
    reset          = 1'b0;
    a_if.ready_out = 1'b1;
    cyc("t_mrst_b", 4'b0010, 1'b1, 32'd1, dat_a(1));
    a_if.valid_in = 4'b0000;
    cyc("t_drain", 4'b0000, 1'b0, 32'd1, dat_a(1));

    // Random handshakes on the 5-input instance, then drain and reconcile.
    do_reset();
    for (int c = 0; c < 400; c++) stress_cycle(1'b0);
    for (int c = 0; c < 8; c++) stress_cycle(1'b1);
    check("b_sb_left", exp_q.size(), 32'd0);
    check("b_count", n_out, n_in);
    check("b_activity", 32'(n_in > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
